// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding-mux select codes and the hazard
// controller state encoding.
package cpu_pkg;

   // Select codes for the EX-stage operand mux4
   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;
   localparam logic [1:0] FWD_ZERO  = 2'd3;

   // Hazard controller sequencing states
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      IF_WAIT  = 2'd3
   } hz_state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/forwarding controller.
// The master side is the pipeline, which reports stage indices and memory
// handshakes. The slave side is the controller, which returns the forwarding
// selects and the stall, bubble and flush enables.
interface hazard_fwd_ctrl_if #(parameter int REG_W = 5);

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic [REG_W-1:0] ex_dst;
   logic             ex_wen;
   logic             ex_mem_read;
   logic [REG_W-1:0] mem_dst;
   logic             mem_wen;
   logic             imem_req;
   logic             imem_ok;
   logic             dmem_req;
   logic             dmem_ok;
   logic             exc_flush;
   logic [1:0]       fwd_a_op;
   logic [1:0]       fwd_b_op;
   logic             stall_if;
   logic             stall_id;
   logic             stall_mem;
   logic             bubble_ex;
   logic             flush_id;

   modport master (
      output id_rs, id_rt, ex_dst, ex_wen, ex_mem_read, mem_dst, mem_wen,
             imem_req, imem_ok, dmem_req, dmem_ok, exc_flush,
      input  fwd_a_op, fwd_b_op, stall_if, stall_id, stall_mem, bubble_ex, flush_id
   );

   modport slave (
      input  id_rs, id_rt, ex_dst, ex_wen, ex_mem_read, mem_dst, mem_wen,
             imem_req, imem_ok, dmem_req, dmem_ok, exc_flush,
      output fwd_a_op, fwd_b_op, stall_if, stall_id, stall_mem, bubble_ex, flush_id
   );

endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Forwarding selects are registered into ID/EX. The stall, bubble and flush
// enables are combinational from the sequencing state and the current inputs,
// so a newly detected hazard takes effect in the same cycle.
module hazard_fwd_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_W = 5
) (
   input logic              clk,
   input logic              rst,
   hazard_fwd_ctrl_if.slave hz
);

   // Operand source choice. $zero always reads as constant zero. The younger
   // producer in EX takes priority over the older producer in MEM.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] idx,
      input logic [REG_W-1:0] e_dst,
      input logic             e_wen,
      input logic [REG_W-1:0] m_dst,
      input logic             m_wen
   );
      if (idx == '0)
         return FWD_ZERO;
      else if (e_wen && (e_dst == idx))
         return FWD_EXMEM;
      else if (m_wen && (m_dst == idx))
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

   hz_state_t  state;
   hz_state_t  state_nxt;
   logic       flush_pend;
   logic       flush_pend_nxt;
   logic       load_use;
   logic       data_wait;
   logic       inst_wait;
   logic       stall_if;
   logic       stall_id;
   logic       stall_mem;
   logic       bubble_ex;
   logic       flush_id;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // Hazard conditions seen this cycle. A memory handshake whose ok pulse
   // arrives together with the request does not count as a wait.
   always_comb begin
      load_use  = hz.ex_mem_read && hz.ex_wen && (hz.ex_dst != '0) &&
                  ((hz.ex_dst == hz.id_rs) || (hz.ex_dst == hz.id_rt));
      data_wait = hz.dmem_req && !hz.dmem_ok;
      inst_wait = hz.imem_req && !hz.imem_ok;
   end

   // Next-state and enable decode. A pending data access dominates everything,
   // including exceptions: the flush is parked in flush_pend and released on the
   // first cycle after the access completes, so a store is never torn. LU_STALL
   // is the cycle after the bubble; the load-use check is masked there so the
   // held instruction advances and picks up the load result by forwarding.
   always_comb begin
      state_nxt      = state;
      flush_pend_nxt = flush_pend;
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      stall_mem      = 1'b0;
      bubble_ex      = 1'b0;
      flush_id       = 1'b0;
      if (!rst) begin
         case (state)
            MEM_WAIT: begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               stall_mem = 1'b1;
               if (hz.exc_flush)
                  flush_pend_nxt = 1'b1;
               if (hz.dmem_ok)
                  state_nxt = RUN;
            end
            default: begin
               if (data_wait) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_mem = 1'b1;
                  state_nxt = MEM_WAIT;
                  if (hz.exc_flush)
                     flush_pend_nxt = 1'b1;
               end else if (hz.exc_flush || flush_pend) begin
                  flush_id       = 1'b1;
                  bubble_ex      = 1'b1;
                  flush_pend_nxt = 1'b0;
                  state_nxt      = RUN;
               end else if (state == IF_WAIT) begin
                  stall_if  = 1'b1;
                  bubble_ex = 1'b1;
                  if (hz.imem_ok)
                     state_nxt = RUN;
               end else if (load_use && (state == RUN)) begin
                  stall_if  = 1'b1;
                  bubble_ex = 1'b1;
                  state_nxt = LU_STALL;
               end else if (inst_wait) begin
                  stall_if  = 1'b1;
                  bubble_ex = 1'b1;
                  state_nxt = IF_WAIT;
               end else begin
                  state_nxt = RUN;
               end
            end
         endcase
      end
   end

   // State, deferred flush and the ID/EX forwarding selects. The selects are
   // cleared whenever a bubble enters EX, held while ID/EX is frozen and
   // otherwise follow the instruction moving from ID into EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         flush_pend <= 1'b0;
         fwd_a      <= FWD_REG;
         fwd_b      <= FWD_REG;
      end else begin
         state      <= state_nxt;
         flush_pend <= flush_pend_nxt;
         if (bubble_ex) begin
            fwd_a <= FWD_REG;
            fwd_b <= FWD_REG;
         end else if (!stall_id) begin
            fwd_a <= fwd_sel(hz.id_rs, hz.ex_dst, hz.ex_wen, hz.mem_dst, hz.mem_wen);
            fwd_b <= fwd_sel(hz.id_rt, hz.ex_dst, hz.ex_wen, hz.mem_dst, hz.mem_wen);
         end
      end
   end

   assign hz.fwd_a_op  = fwd_a;
   assign hz.fwd_b_op  = fwd_b;
   assign hz.stall_if  = stall_if;
   assign hz.stall_id  = stall_id;
   assign hz.stall_mem = stall_mem;
   assign hz.bubble_ex = bubble_ex;
   assign hz.flush_id  = flush_id;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl. Each step drives one cycle of pipeline
// inputs and pushes the expected enables and the next-cycle forwarding selects
// onto a queue. The entry is popped when the outputs are sampled.
// The ctl vector is ordered {stall_if, stall_id, stall_mem, bubble_ex, flush_id}.
module tb_hazard_fwd_ctrl;
   import cpu_pkg::*;

   localparam logic [4:0] CTL_NONE  = 5'b00000;
   localparam logic [4:0] CTL_HOLD  = 5'b10010;
   localparam logic [4:0] CTL_MEM   = 5'b11100;
   localparam logic [4:0] CTL_FLUSH = 5'b00011;

   typedef struct {
      string      tag;
      logic [4:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;

   hazard_fwd_ctrl_if #(.REG_W(5)) hz ();

   hazard_fwd_ctrl #(.REG_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // 100 MHz core clock
   always #5 clk = ~clk;

   // Drive one cycle of inputs on the falling edge and queue what should come back
   task automatic applyStimulus(input string tag, input logic rstV,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] exDst, input logic exWen, input logic exRd,
                                input logic [4:0] memDst, input logic memWen,
                                input logic iReq, input logic iOk,
                                input logic dReq, input logic dOk, input logic exc,
                                input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      @(negedge clk);
      rst            = rstV;
      hz.id_rs       = rs;
      hz.id_rt       = rt;
      hz.ex_dst      = exDst;
      hz.ex_wen      = exWen;
      hz.ex_mem_read = exRd;
      hz.mem_dst     = memDst;
      hz.mem_wen     = memWen;
      hz.imem_req    = iReq;
      hz.imem_ok     = iOk;
      hz.dmem_req    = dReq;
      hz.dmem_ok     = dOk;
      hz.exc_flush   = exc;
      e.tag = tag;
      e.ctl = ctl;
      e.fa  = fa;
      e.fb  = fb;
      expQ.push_back(e);
   endtask

   // Sample the enables mid-cycle, then the registered selects just after the edge
   task automatic checkOutput();
      exp_t       e;
      logic [4:0] ctlObs;
      if (expQ.size() == 0) begin
         assertCount++;
         failCount++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
         return;
      end
      e = expQ.pop_front();
      #2;
      ctlObs = {hz.stall_if, hz.stall_id, hz.stall_mem, hz.bubble_ex, hz.flush_id};
      assertCount++;
      assert (ctlObs === e.ctl) else begin
         failCount++;
         $error("[TB] FAIL %s.ctl observed=%b expected=%b", e.tag, ctlObs, e.ctl);
      end
      @(posedge clk);
      #1;
      assertCount++;
      assert (hz.fwd_a_op === e.fa) else begin
         failCount++;
         $error("[TB] FAIL %s.fwd_a observed=%0d expected=%0d", e.tag, hz.fwd_a_op, e.fa);
      end
      assertCount++;
      assert (hz.fwd_b_op === e.fb) else begin
         failCount++;
         $error("[TB] FAIL %s.fwd_b observed=%0d expected=%0d", e.tag, hz.fwd_b_op, e.fb);
      end
   endtask

   // Safety net so the run always ends even if the clock or a step stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence. Args: tag, rst, rs, rt, exDst, exWen, exRd, memDst, memWen,
   // iReq, iOk, dReq, dOk, exc, expected ctl, expected fwd_a/fwd_b after the edge
   initial begin
      rst = 1'b1;
      hz.id_rs = '0; hz.id_rt = '0; hz.ex_dst = '0; hz.ex_wen = 1'b0;
      hz.ex_mem_read = 1'b0; hz.mem_dst = '0; hz.mem_wen = 1'b0;
      hz.imem_req = 1'b0; hz.imem_ok = 1'b0; hz.dmem_req = 1'b0;
      hz.dmem_ok = 1'b0; hz.exc_flush = 1'b0;

      applyStimulus("reset", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("ex_wins", 0, 8, 2, 8, 1, 0, 8, 1, 0, 0, 0, 0, 0, CTL_NONE, FWD_EXMEM, FWD_REG); checkOutput();
      applyStimulus("zero_memwb", 0, 9, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, CTL_NONE, FWD_MEMWB, FWD_ZERO); checkOutput();
      applyStimulus("lu_stall", 0, 8, 2, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_HOLD, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("lu_resume", 0, 8, 2, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_EXMEM, FWD_REG); checkOutput();
      applyStimulus("pre_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_ZERO, FWD_ZERO); checkOutput();
      for (int c = 0; c < 4; c++) begin
         applyStimulus($sformatf("mem_wait_c%0d", c), 0, 3, 4, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, CTL_MEM, FWD_ZERO, FWD_ZERO);
         checkOutput();
      end
      applyStimulus("mem_ok_c4", 0, 3, 4, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, CTL_MEM, FWD_ZERO, FWD_ZERO); checkOutput();
      applyStimulus("mem_done_c5", 0, 3, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_EXMEM, FWD_REG); checkOutput();
      applyStimulus("if_wait_in", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, CTL_HOLD, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("if_wait_hold", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, CTL_HOLD, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("if_to_mem", 0, 5, 2, 5, 1, 0, 0, 0, 1, 0, 1, 0, 0, CTL_MEM, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("flush_defer", 0, 5, 2, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, CTL_MEM, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("flush_mem_ok", 0, 5, 2, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, CTL_MEM, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("flush_release", 0, 5, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, CTL_FLUSH, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("after_flush", 0, 6, 2, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, CTL_NONE, FWD_MEMWB, FWD_REG); checkOutput();
      applyStimulus("exc_in_run", 0, 6, 2, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, CTL_FLUSH, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("mem_beats_lu", 0, 7, 2, 7, 1, 1, 0, 0, 0, 0, 1, 0, 0, CTL_MEM, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("mem_beats_lu_ok", 0, 7, 2, 7, 1, 1, 0, 0, 0, 0, 1, 1, 0, CTL_MEM, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("lu_after_mem", 0, 7, 2, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_HOLD, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("lu_after_mem_go", 0, 7, 2, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_EXMEM, FWD_REG); checkOutput();
      applyStimulus("ok_same_cycle", 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, CTL_NONE, FWD_ZERO, FWD_REG); checkOutput();
      applyStimulus("rst_pre_wait", 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, CTL_MEM, FWD_ZERO, FWD_REG); checkOutput();
      applyStimulus("rst_mid_wait", 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, CTL_NONE, FWD_REG, FWD_REG); checkOutput();
      applyStimulus("rst_released", 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NONE, FWD_REG, FWD_REG); checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
